// File: rtl/pulse_param_regfile.sv
// pulse_param_regfile
//   UART command decoder and pulse-parameter register file. A frame is
//   PAYLOAD_BYTES data bytes (LSB first) followed by one command byte:
//   bit7 = 1 READ, 0 WRITE; bits[6:0] = register index. Every frame is
//   answered over the TX byte interface (checksum, read data, or ~checksum
//   for an out-of-range index).
//
//   Optional feature macro: PPR_RX_TIMEOUT_EN
//     defined   -> a partial frame is discarded after TIMEOUT_CYC idle cycles
//     undefined -> a partial frame waits indefinitely for its remaining bytes
//
//   Handshake: rx_valid is a one-cycle strobe with no back-pressure; bytes
//   arriving outside RX are discarded and flagged on rx_drop in the same
//   cycle. tx_start is a one-cycle request issued only while tx_ready is
//   high; tx_byte is held stable from tx_start until the next request.
//
//   state_dbg exposes the FSM state (RX=0, EXEC=1, TX_REQ=2, TX_HOLD=3,
//   TX_WAIT=4) for checkers.
module pulse_param_regfile #(
  parameter int                        NUM_REGS      = 8,
  parameter int                        REG_W         = 32,
  parameter int                        PAYLOAD_BYTES = 4,
  parameter logic [NUM_REGS*REG_W-1:0] RST_VALS      = '0,
  parameter int                        TIMEOUT_CYC   = 100500
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  input  logic                      tx_ready,
  output logic                      tx_start,
  output logic [7:0]                tx_byte,
  output logic [NUM_REGS*REG_W-1:0] regs_flat,
  output logic                      upd,
  output logic [6:0]                upd_idx,
  output logic                      rx_drop,
  output logic                      busy,
  output logic [2:0]                state_dbg
);

  localparam int PW    = PAYLOAD_BYTES * 8;
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);

  // Elaboration-time parameter sanity checks
  if (PW < REG_W) begin : g_bad_width
    $error("pulse_param_regfile: PAYLOAD_BYTES*8 (%0d) < REG_W (%0d)", PW, REG_W);
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("pulse_param_regfile: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_RX      = 3'd0,
    ST_EXEC    = 3'd1,
    ST_TX_REQ  = 3'd2,
    ST_TX_HOLD = 3'd3,
    ST_TX_WAIT = 3'd4
  } state_t;

  state_t                    state_q,    state_d;
  logic [CNT_W-1:0]          cnt_q,      cnt_d;
  logic [PW-1:0]             payload_q,  payload_d;
  logic [7:0]                cmd_q,      cmd_d;
  logic [NUM_REGS*REG_W-1:0] regs_q,     regs_d;
  logic [PW-1:0]             resp_q,     resp_d;
  logic [CNT_W-1:0]          resp_len_q, resp_len_d;
  logic [CNT_W-1:0]          ptr_q,      ptr_d;
  logic                      tx_start_q, tx_start_d;
  logic [7:0]                tx_byte_q,  tx_byte_d;
  logic                      upd_q,      upd_d;
  logic [6:0]                upd_idx_q,  upd_idx_d;

`ifdef PPR_RX_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  logic [6:0]       cmd_idx;
  logic             idx_ok;
  logic [7:0]       chk;
  logic [REG_W-1:0] rd_word;
  logic [7:0]       cur_byte;

  assign cmd_idx = cmd_q[6:0];
  assign idx_ok  = (32'(cmd_idx) < 32'(NUM_REGS));

  // Checksum of the payload, addressed register read-out and current response byte
  always_comb begin
    chk = '0;
    for (int j = 0; j < PAYLOAD_BYTES; j++) begin
      chk = chk + payload_q[j*8 +: 8];
    end
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (7'(i) == cmd_idx) rd_word = regs_q[i*REG_W +: REG_W];
    end
    cur_byte = '0;
    for (int j = 0; j < PAYLOAD_BYTES; j++) begin
      if (CNT_W'(j) == ptr_q) cur_byte = resp_q[j*8 +: 8];
    end
  end

  // Next-state logic: frame assembly, command execution and response sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    payload_d  = payload_q;
    cmd_d      = cmd_q;
    regs_d     = regs_q;
    resp_d     = resp_q;
    resp_len_d = resp_len_q;
    ptr_d      = ptr_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    upd_d      = 1'b0;
    upd_idx_d  = upd_idx_q;
`ifdef PPR_RX_TIMEOUT_EN
    tmo_d      = '0;
`endif

    case (state_q)
      ST_RX: begin
        if (rx_valid) begin
          if (cnt_q == CNT_W'(PAYLOAD_BYTES)) begin
            cmd_d   = rx_byte;
            cnt_d   = '0;
            state_d = ST_EXEC;
          end else begin
            for (int j = 0; j < PAYLOAD_BYTES; j++) begin
              if (CNT_W'(j) == cnt_q) payload_d[j*8 +: 8] = rx_byte;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef PPR_RX_TIMEOUT_EN
        // Idle time inside a partial frame; on expiry the frame is dropped silently
        if (cnt_q != '0 && !rx_valid) begin
          if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            cnt_d = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
`endif
      end

      ST_EXEC: begin
        resp_d = '0;
        ptr_d  = '0;
        if (idx_ok && !cmd_q[7]) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (7'(i) == cmd_idx) regs_d[i*REG_W +: REG_W] = payload_q[REG_W-1:0];
          end
          upd_d       = 1'b1;
          upd_idx_d   = cmd_idx;
          resp_d[7:0] = chk;
          resp_len_d  = CNT_W'(1);
        end else if (idx_ok) begin
          resp_d[REG_W-1:0] = rd_word;
          resp_len_d        = CNT_W'(PAYLOAD_BYTES);
        end else begin
          resp_d[7:0] = ~chk;
          resp_len_d  = CNT_W'(1);
        end
        // First byte may launch straight from EXEC so it leaves two cycles after the command
        if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_byte_d  = resp_d[7:0];
          state_d    = ST_TX_HOLD;
        end else begin
          state_d = ST_TX_REQ;
        end
      end

      ST_TX_REQ: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_byte_d  = cur_byte;
          state_d    = ST_TX_HOLD;
        end
      end

      // The UART needs a cycle to drop tx_ready after tx_start
      ST_TX_HOLD: begin
        state_d = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        if (tx_ready) begin
          if ((ptr_q + CNT_W'(1)) < resp_len_q) begin
            ptr_d   = ptr_q + CNT_W'(1);
            state_d = ST_TX_REQ;
          end else begin
            state_d = ST_RX;
          end
        end
      end

      default: state_d = ST_RX;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RX;
      cnt_q      <= '0;
      payload_q  <= '0;
      cmd_q      <= '0;
      regs_q     <= RST_VALS;
      resp_q     <= '0;
      resp_len_q <= '0;
      ptr_q      <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      upd_q      <= 1'b0;
      upd_idx_q  <= '0;
`ifdef PPR_RX_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      cmd_q      <= cmd_d;
      regs_q     <= regs_d;
      resp_q     <= resp_d;
      resp_len_q <= resp_len_d;
      ptr_q      <= ptr_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      upd_q      <= upd_d;
      upd_idx_q  <= upd_idx_d;
`ifdef PPR_RX_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_byte   = tx_byte_q;
  assign regs_flat = regs_q;
  assign upd       = upd_q;
  assign upd_idx   = upd_idx_q;
  assign busy      = (state_q != ST_RX);
  assign rx_drop   = rx_valid && (state_q != ST_RX);
  assign state_dbg = state_q;

endmodule
